// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side packer.
package fifo_pkg;

   localparam int FIFO_WIDTH_DEF = 16;

   typedef logic [1:0] keep_t;

   localparam keep_t KEEP_NONE = 2'b00;
   localparam keep_t KEEP_LOW  = 2'b01;
   localparam keep_t KEEP_FULL = 2'b11;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

endpackage

// File: rtl/fifo_word_buf.sv
// Circular word buffer: one push per cycle, pop of one or two words from the head,
// with the two oldest words always visible.
module fifo_word_buf #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop1,
   input  logic             pop2,
   output logic [WIDTH-1:0] word0,
   output logic [WIDTH-1:0] word1,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointer advance with explicit wrap so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = 32'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return s[PW-1:0];
   endfunction

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_add(wr_ptr_q, 1);
      end
      if (pop2) begin
         rd_ptr_d = ptr_add(rd_ptr_q, 2);
      end else if (pop1) begin
         rd_ptr_d = ptr_add(rd_ptr_q, 1);
      end
      count_d = count_q + CW'(push) - (pop2 ? CW'(2) : CW'(pop1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign word0 = mem_q[rd_ptr_q];
   assign word1 = mem_q[ptr_add(rd_ptr_q, 1)];
   assign count = count_q;

endmodule

// File: rtl/fifo_drain_packer.sv
// Read-side FIFO consumer: pops words, packs pairs into double-width beats on a
// valid/ready stream, and emits a trailing odd word as a half beat on flush or idle timeout.
module fifo_drain_packer
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int BUF_WORDS  = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fifo_empty,
   input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
   output logic                    fifo_rd_en,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [2*FIFO_WIDTH-1:0] m_data,
   output keep_t                   m_keep,
   input  logic                    flush,
   output logic                    flush_done,
   output logic                    busy,
   output drain_state_e            dbg_state
);

   localparam int CW = $clog2(BUF_WORDS + 1);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   // Stream handshake: a beat transfers on any rising edge where m_valid && m_ready;
   // m_valid/m_data/m_keep never change while m_valid && !m_ready.

   drain_state_e            state_q, state_d;
   logic                    inflight_q, inflight_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    m_valid_q, m_valid_d;
   logic [2*FIFO_WIDTH-1:0] m_data_q, m_data_d;
   keep_t                   m_keep_q, m_keep_d;

   logic [FIFO_WIDTH-1:0]   word0, word1;
   logic [CW-1:0]           buf_count;
   int                      occupancy;
   logic                    rd_issue, out_free, tmo_arm, tmo_fire;
   logic                    load_full, load_half, drain_done;

   fifo_word_buf #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (BUF_WORDS)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (fifo_data_out),
      .pop1      (load_half),
      .pop2      (load_full),
      .word0     (word0),
      .word1     (word1),
      .count     (buf_count)
   );

   // Reads are budgeted against words already held plus the one in flight.
   always_comb begin
      occupancy  = 32'(buf_count) + 32'(inflight_q);
      rd_issue   = rst_n && !fifo_empty && (state_q == RUN) && (occupancy < BUF_WORDS);
      out_free   = !m_valid_q || m_ready;
      tmo_arm    = (buf_count == CW'(1)) && !inflight_q && fifo_empty;
      tmo_fire   = (TIMEOUT != 0) && tmo_arm && (tmo_q == TW'(TIMEOUT));
      load_full  = out_free && (buf_count >= CW'(2));
      load_half  = out_free && (buf_count == CW'(1)) && !inflight_q
                   && ((state_q == DRAIN) || tmo_fire);
      drain_done = (state_q == DRAIN) && !inflight_q && (buf_count == '0) && out_free;
   end

   always_comb begin
      inflight_d = rd_issue;
      if (!tmo_arm) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT)) begin
         tmo_d = load_half ? '0 : tmo_q;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      if (load_full) begin
         m_valid_d = 1'b1;
         m_data_d  = {word1, word0};
         m_keep_d  = KEEP_FULL;
      end else if (load_half) begin
         m_valid_d = 1'b1;
         m_data_d  = {{FIFO_WIDTH{1'b0}}, word0};
         m_keep_d  = KEEP_LOW;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         tmo_q      <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_keep_q   <= KEEP_NONE;
      end else begin
         inflight_q <= inflight_d;
         tmo_q      <= tmo_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_keep_q   <= m_keep_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // A flush arriving while already draining is absorbed by the drain in progress.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush)      state_d = DRAIN;
         DRAIN:   if (drain_done) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      fifo_rd_en = rd_issue;
      flush_done = drain_done;
      busy       = (buf_count != '0) || inflight_q || m_valid_q || (state_q == DRAIN);
      dbg_state  = state_q;
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_keep  = m_keep_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer: a queue-backed FIFO model feeds the DUT and a
// scoreboard of expected {keep, data} beats checks everything the sink accepts.
module tb_fifo_drain_packer;
   import fifo_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         fifo_empty;
   logic [15:0]  fifo_data_out;
   logic         fifo_rd_en;
   logic         m_valid;
   logic         m_ready;
   logic [31:0]  m_data;
   keep_t        m_keep;
   logic         flush;
   logic         flush_done;
   logic         busy;
   drain_state_e dbg_state;

   logic [15:0] fq[$];
   logic [33:0] exp_q[$];
   int          beat_cyc[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          fd_cnt = 0;
   int          fd_fq = 0;
   int          rd_drain_cnt = 0;
   int          start_cyc;
   int          d;

   fifo_drain_packer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_rd_en    (fifo_rd_en),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_keep        (m_keep),
      .flush         (flush),
      .flush_done    (flush_done),
      .busy          (busy),
      .dbg_state     (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      fq.push_back(w);
      fifo_empty = 1'b0;
   endtask

   function automatic logic [33:0] full_beat(input logic [15:0] w1, input logic [15:0] w0);
      return {KEEP_FULL, w1, w0};
   endfunction

   function automatic logic [33:0] half_beat(input logic [15:0] w0);
      return {KEEP_LOW, 16'h0000, w0};
   endfunction

   // One clock: sample DUT outputs settled before the edge, then advance the FIFO model.
   task automatic tick();
      logic         rd, mv, mr, fd;
      drain_state_e st;
      logic [33:0]  beat;
      #1;
      rd   = fifo_rd_en;
      mv   = m_valid;
      mr   = m_ready;
      fd   = flush_done;
      st   = dbg_state;
      beat = {m_keep, m_data};
      @(posedge clk);
      #1;
      if (rd) begin
         if (fq.size() == 0) check("read_when_empty", fq.size(), 1);
         else fifo_data_out = fq.pop_front();
         if (st == DRAIN) rd_drain_cnt++;
      end
      fifo_empty = (fq.size() == 0);
      if (mv && mr) begin
         beat_cyc.push_back(cyc);
         if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
         else check("beat", beat, exp_q.pop_front());
      end
      if (fd) begin
         fd_cnt++;
         fd_fq = fq.size();
      end
      cyc++;
      #1;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
         tick();
         n++;
      end
      check({tag, "_beats_left"}, exp_q.size(), 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      fifo_empty    = 1'b1;
      fifo_data_out = '0;
      m_ready       = 1'b0;
      flush         = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_keep", m_keep, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // Stream: two full beats, first valid in cycle 4, then one every two cycles.
      m_ready = 1'b1;
      beat_cyc.delete();
      exp_q.push_back(full_beat(16'h2222, 16'h1111));
      exp_q.push_back(full_beat(16'h4444, 16'h3333));
      start_cyc = cyc;
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      push_word(16'h4444);
      wait_idle("stream", 40);
      check("stream_beat_count", beat_cyc.size(), 2);
      if (beat_cyc.size() == 2) begin
         check("stream_first_valid_cycle", beat_cyc[0] - start_cyc, 4);
         check("stream_beat_spacing", beat_cyc[1] - beat_cyc[0], 2);
      end

      // Timeout: a lone word leaves as a low half beat after the idle window.
      beat_cyc.delete();
      exp_q.push_back(half_beat(16'hABCD));
      start_cyc = cyc;
      push_word(16'hABCD);
      wait_idle("timeout", 40);
      check("timeout_beat_count", beat_cyc.size(), 1);
      if (beat_cyc.size() == 1) begin
         d = beat_cyc[0] - start_cyc;
         check("timeout_latency_window", (d >= 16) && (d <= 19), 1);
      end

      // Flush with three words: full pair, then odd word as half, single done pulse.
      fd_cnt = 0;
      exp_q.push_back(full_beat(16'h5002, 16'h5001));
      exp_q.push_back(half_beat(16'h5003));
      push_word(16'h5001);
      push_word(16'h5002);
      push_word(16'h5003);
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_idle("flush", 40);
      check("flush_done_pulses", fd_cnt, 1);
      check("flush_state_run", dbg_state, RUN);

      // Flush in the same cycle a read is accepted: the in-flight word is drained,
      // and nothing more is read until the block is back in RUN.
      fd_cnt       = 0;
      rd_drain_cnt = 0;
      exp_q.push_back(half_beat(16'h6001));
      exp_q.push_back(full_beat(16'h6003, 16'h6002));
      push_word(16'h6001);
      push_word(16'h6002);
      push_word(16'h6003);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_idle("simul", 40);
      check("simul_flush_done_pulses", fd_cnt, 1);
      check("simul_fifo_left_at_done", fd_fq, 2);
      check("simul_reads_in_drain", rd_drain_cnt, 0);

      // Backpressure: eight words, sink stalled for 20 cycles.
      m_ready = 1'b0;
      beat_cyc.delete();
      for (int i = 0; i < 8; i += 2) begin
         exp_q.push_back(full_beat(16'hA000 + 16'(i + 1), 16'hA000 + 16'(i)));
      end
      for (int i = 0; i < 8; i++) push_word(16'hA000 + 16'(i));
      repeat (6) tick();
      check("bp_valid_early", m_valid, 1);
      check("bp_data_early", {m_keep, m_data}, full_beat(16'hA001, 16'hA000));
      repeat (14) tick();
      check("bp_data_held", {m_keep, m_data}, full_beat(16'hA001, 16'hA000));
      check("bp_rd_stopped", fifo_rd_en, 0);
      check("bp_fifo_left", fq.size(), 2);
      check("bp_no_beats", beat_cyc.size(), 0);
      m_ready = 1'b1;
      wait_idle("bp", 60);
      check("bp_beat_count", beat_cyc.size(), 4);

      // Reset mid-stream with the output register loaded and words still in the FIFO.
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(16'hC000 + 16'(i));
      repeat (6) tick();
      check("mid_fifo_left", fq.size(), 2);
      check("mid_valid_before_rst", m_valid, 1);
      check("mid_data_before_rst", m_data, 32'hC001C000);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd_en", fifo_rd_en, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_m_data", m_data, 0);
      check("mid_rst_m_keep", m_keep, 0);
      check("mid_rst_flush_done", flush_done, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) tick();
      check("mid_rst_no_reads", fq.size(), 2);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      exp_q.push_back(full_beat(16'hC007, 16'hC006));
      wait_idle("mid_resume", 40);
      check("mid_fifo_drained", fq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
